aes_shiftrows_pipe: RTL and testbench

Parametrised, pipelined ShiftRows / InvShiftRows engine for the AES/Rijndael datapath. It replaces the bare combinational InvShiftRows.
- Supports Rijndael block widths Nb = 4, 6 or 8 columns.
- Direction (forward or inverse) is selectable per transaction.
- Carries a caller tag alongside each block.
- Uses valid/ready handshakes with full backpressure.
- Sits between the SubBytes/InvSubBytes and MixColumns/InvMixColumns stages of the round pipeline.

---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_pipe_slot.sv | 26 ++
 rtl/aes_shiftrows_pipe.sv | 90 +++++++++
 tb/tb_aes_shiftrows_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types, legal Rijndael widths and row shifts.
// Items: aes_dir_e, NB_128/192/256, nb_legal(), shift_off().
package aes_pkg;

  typedef enum logic {
    AES_FWD = 1'b0,
    AES_INV = 1'b1
  } aes_dir_e;

  localparam int NB_128 = 4;
  localparam int NB_192 = 6;
  localparam int NB_256 = 8;

  function automatic bit nb_legal(input int nb);
    return (nb == NB_128) ||
           (nb == NB_192) ||
           (nb == NB_256);
  endfunction

  // Row shift Cr; only Nb=8 differs (rows 2/3).
  function automatic int shift_off(
    input int nb,
    input int r
  );
    int off;
    off = r;
    if (nb == NB_256 && r >= 2) off = r + 1;
    return off;
  endfunction

endpackage

// File: rtl/aes_pipe_slot.sv
// One valid/ready register slot carrying a W-bit payload.
// Ports: clk, rst_n, load, up_valid, up_data -> valid, data.
module aes_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= up_valid;
      // payload only captured for a real block
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/aes_shiftrows_pipe.sv
// Pipelined ShiftRows/InvShiftRows for Rijndael Nb=4/6/8.
// Ports: in_valid/in_ready/in_mode/in_tag/in_data -> out_valid/out_ready/out_tag/out_data.
module aes_shiftrows_pipe
  import aes_pkg::*;
#(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [0:32*NB-1] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [0:32*NB-1] out_data
);

  localparam int DW = 32 * NB;
  localparam int W  = TAG_W + DW;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_ps
    $error("aes_shiftrows_pipe: PIPE_STAGES must be 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_shiftrows_pipe: TAG_W must be >= 1");
  end

  aes_dir_e        dir;
  logic [0:DW-1]   perm;

  assign dir = aes_dir_e'(in_mode);

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int OFF = shift_off(NB, r);
      localparam int FC  = (c + OFF) % NB;
      localparam int IC  = (c - OFF + NB) % NB;
      assign perm[8*(4*c+r) +: 8] =
        (dir == AES_INV) ?
        in_data[8*(4*IC+r) +: 8] :
        in_data[8*(4*FC+r) +: 8];
    end
  end

  logic         vld [0:PIPE_STAGES];
  logic [W-1:0] pay [0:PIPE_STAGES];
  logic         ld  [0:PIPE_STAGES-1];

  assign vld[0] = in_valid;
  assign pay[0] = {in_tag, perm};

  // Slot i loads when out_ready is high or any
  // slot from i onward is empty (free bubble).
  always_comb begin
    logic full;
    full = 1'b1;
    for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
      full  = full & vld[i+1];
      ld[i] = out_ready | ~full;
    end
  end

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_slot
    aes_pipe_slot #(
      .W(W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld[k]),
      .up_valid (vld[k]),
      .up_data  (pay[k]),
      .valid    (vld[k+1]),
      .data     (pay[k+1])
    );
  end

  assign in_ready  = rst_n & ld[0];
  assign out_valid = vld[PIPE_STAGES];
  assign out_tag   = pay[PIPE_STAGES][W-1 -: TAG_W];
  assign out_data  = pay[PIPE_STAGES][DW-1:0];

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Bench for aes_shiftrows_pipe: NB=4/P=1, NB=4/P=3, NB=8/P=2.
// Random streams scored against a row-rotation reference model.
module tb_aes_shiftrows_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // DUT A: NB=4, P=1
  logic         a_in_valid, a_in_ready, a_in_mode;
  logic [3:0]   a_in_tag, a_out_tag;
  logic [0:127] a_in_data, a_out_data;
  logic         a_out_valid, a_out_ready;

  // DUT B: NB=4, P=3
  logic         b_in_valid, b_in_ready, b_in_mode;
  logic [3:0]   b_in_tag, b_out_tag;
  logic [0:127] b_in_data, b_out_data;
  logic         b_out_valid, b_out_ready;

  // DUT C: NB=8, P=2
  logic         c_in_valid, c_in_ready, c_in_mode;
  logic [3:0]   c_in_tag, c_out_tag;
  logic [0:255] c_in_data, c_out_data;
  logic         c_out_valid, c_out_ready;

  aes_shiftrows_pipe #(
    .NB(4), .PIPE_STAGES(1), .TAG_W(4)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mode(a_in_mode), .in_tag(a_in_tag),
    .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_tag(a_out_tag), .out_data(a_out_data)
  );

  aes_shiftrows_pipe #(
    .NB(4), .PIPE_STAGES(3), .TAG_W(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mode(b_in_mode), .in_tag(b_in_tag),
    .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_tag(b_out_tag), .out_data(b_out_data)
  );

  aes_shiftrows_pipe #(
    .NB(8), .PIPE_STAGES(2), .TAG_W(4)
  ) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_mode(c_in_mode), .in_tag(c_in_tag),
    .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_tag(c_out_tag), .out_data(c_out_data)
  );

  task automatic chk(
    input string        t,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", t, obs, exp);
    end
  endtask

  // Reference: rotate each row r left by Cr (fwd) or right (inv).
  function automatic logic [0:255] ref_sr(
    input int           nb,
    input bit           inv,
    input logic [0:255] d
  );
    int off [4];
    logic [0:255] o;
    int sc;
    o = '0;
    off = '{0, 1, 2, 3};
    if (nb == 8) off = '{0, 1, 3, 4};
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (inv) sc = (c - off[r] + nb) % nb;
        else     sc = (c + off[r]) % nb;
        o[8*(4*c+r) +: 8] = d[8*(4*sc+r) +: 8];
      end
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream nblk random blocks into DUT B with out_ready low
  // over cycles [st_lo, st_hi]; scoreboard every output.
  task automatic run_b(
    input string nm,
    input int    nblk,
    input int    st_lo,
    input int    st_hi,
    input bit    rnd,
    input int    exp_drop,
    input bit    chk_tp
  );
    logic [0:127] eq [$];
    logic [3:0]   tq [$];
    logic [0:255] tmp;
    logic [0:127] held_d;
    logic [3:0]   held_t;
    bit held;
    int sent, got, drop, first, last, dup;
    sent = 0; got = 0; drop = -1;
    first = -1; last = -1; held = 0; dup = 0;
    for (int cyc = 0; cyc < 200 && got < nblk; cyc++) begin
      b_in_valid  = (sent < nblk);
      b_in_mode   = rnd ? 1'($urandom) : 1'b0;
      b_in_tag    = 4'(sent);
      b_in_data   = {$urandom, $urandom, $urandom, $urandom};
      b_out_ready = !(cyc >= st_lo && cyc <= st_hi);
      @(negedge clk);
      if (held) begin
        chk({nm, "_hold_data"}, b_out_data, held_d);
        chk({nm, "_hold_tag"}, b_out_tag, held_t);
      end
      held   = b_out_valid && !b_out_ready;
      held_d = b_out_data;
      held_t = b_out_tag;
      if (b_out_valid && b_out_ready) begin
        if (eq.size() == 0) begin
          dup++;
        end else begin
          chk({nm, "_data"}, b_out_data, eq.pop_front());
          chk({nm, "_tag"}, b_out_tag, tq.pop_front());
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (b_in_valid && b_in_ready) begin
        tmp = '0;
        tmp[0:127] = b_in_data;
        tmp = ref_sr(4, b_in_mode, tmp);
        eq.push_back(tmp[0:127]);
        tq.push_back(b_in_tag);
        sent++;
      end else if (b_in_valid && drop < 0) begin
        drop = sent;
      end
      tick();
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    chk({nm, "_count"}, got, nblk);
    chk({nm, "_extra"}, dup, 0);
    chk({nm, "_drop"}, drop, exp_drop);
    if (chk_tp) begin
      chk({nm, "_first"}, first, 3);
      chk({nm, "_span"}, last - first, nblk - 1);
    end
  endtask

  logic [0:255] cv, cr;
  int           seen;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_in_mode = 0; a_in_tag = 0;
    a_in_data = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_mode = 0; b_in_tag = 0;
    b_in_data = '0; b_out_ready = 1;
    c_in_valid = 0; c_in_mode = 0; c_in_tag = 0;
    c_in_data = '0; c_out_ready = 1;
    repeat (2) tick();

    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_tag", a_out_tag, 0);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_b_ready", b_in_ready, 0);
    chk("rst_c_valid", c_out_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", a_in_ready, 1);

    // FIPS-197 forward
    a_in_valid = 1; a_in_mode = 0; a_in_tag = 3;
    a_in_data = 128'hd42711aee0bf98f1b8b45de51e415230;
    tick();
    a_in_valid = 0;
    chk("fips_valid", a_out_valid, 1);
    chk("fips_data", a_out_data,
        128'hd4bf5d30e0b452aeb84111f11e2798e5);
    chk("fips_tag", a_out_tag, 3);

    // inverse round trip
    a_in_valid = 1; a_in_mode = 1; a_in_tag = 5;
    a_in_data = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    tick();
    a_in_valid = 0;
    chk("inv_data", a_out_data,
        128'hd42711aee0bf98f1b8b45de51e415230);
    chk("inv_tag", a_out_tag, 5);

    a_in_valid = 1; a_in_mode = 1; a_in_tag = 9;
    a_in_data = 128'h0123456789abcdef0123456789abcdef;
    tick();
    a_in_valid = 0;
    chk("inv2_data", a_out_data,
        128'h01ab45ef8923cd6701ab45ef8923cd67);
    tick();
    chk("idle_valid", a_out_valid, 0);

    // NB=8 pattern byte(r,c) = 4c+r
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++)
        cv[8*(4*c+r) +: 8] = 8'(4*c + r);
    c_in_valid = 1; c_in_mode = 0; c_in_tag = 7;
    c_in_data = cv;
    tick();
    c_in_valid = 0;
    chk("nb8_lat1", c_out_valid, 0);
    tick();
    chk("nb8_lat2", c_out_valid, 1);
    chk("nb8_fwd", c_out_data, ref_sr(8, 0, cv));
    chk("nb8_r1c0", c_out_data[8 +: 8], 8'd5);
    chk("nb8_r2c0", c_out_data[16 +: 8], 8'd14);
    chk("nb8_r3c0", c_out_data[24 +: 8], 8'd19);
    cr = c_out_data;
    c_in_valid = 1; c_in_mode = 1; c_in_tag = 2;
    c_in_data = cr;
    repeat (2) tick();
    c_in_valid = 0;
    chk("nb8_inv", c_out_data, cv);
    chk("nb8_inv_tag", c_out_tag, 2);

    // backpressure and full throughput on P=3
    run_b("bp", 6, 2, 7, 1'b0, 3, 1'b0);
    repeat (3) tick();
    run_b("tp", 16, -1, -1, 1'b1, -1, 1'b1);
    repeat (3) tick();

    // reset with two blocks in flight
    b_in_mode = 0;
    b_in_valid = 1; b_in_tag = 4'hA;
    b_in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    b_in_tag = 4'hB;
    tick();
    b_in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", b_in_ready, 0);
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", b_out_valid, 0);
    chk("midrst_tag", b_out_tag, 0);
    chk("midrst_data", b_out_data, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b_out_valid) seen++;
    end
    chk("midrst_ghost", seen, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
